// File: rtl/video_clken_gen.sv
// video_clken_gen: NUM_CLOCKS independent fractional clock-enable generators
// derived from refclk. Each channel has a phase accumulator that produces
// enables at f_ref*num/den and a matching toggle clock at half that rate.
// A lock monitor reports when every channel has been running steadily for
// LOCK_CYCLES edges.
// Optional feature macro: VIDEO_CLKGEN_CFG_EN. When it is defined, the run-time
// ratio write port is present. When it is undefined, the cfg inputs are
// ignored, cfg_ready is 0 and every channel stays at 1/1.
module video_clken_gen #(
  parameter int  NUM_CLOCKS  = 3,
  parameter int  ACC_W       = 16,
  parameter int  LOCK_CYCLES = 1024,
  localparam int CH_W        = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1
) (
  input  logic                  refclk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [CH_W-1:0]       cfg_chan,
  input  logic [ACC_W-1:0]      cfg_num,
  input  logic [ACC_W-1:0]      cfg_den,
  output logic [NUM_CLOCKS-1:0] clken,
  output logic [NUM_CLOCKS-1:0] outclk,
  output logic                  locked
);

  localparam int             LCW      = $clog2(LOCK_CYCLES + 1);
  localparam logic [LCW-1:0] LOCK_MAX = LCW'(LOCK_CYCLES);

  logic [NUM_CLOCKS-1:0][ACC_W-1:0] num_q, num_d;
  logic [NUM_CLOCKS-1:0][ACC_W-1:0] den_q, den_d;
  logic [NUM_CLOCKS-1:0][ACC_W-1:0] acc_q, acc_d;
  logic [NUM_CLOCKS-1:0]            clken_q, clken_d;
  logic [NUM_CLOCKS-1:0]            outclk_q, outclk_d;
  logic [LCW-1:0]                   cnt_q, cnt_d;
  logic                             locked_q, locked_d;
  logic [ACC_W:0]                   sum;
  logic                             wr_hit;

`ifdef VIDEO_CLKGEN_CFG_EN
  // A write is taken only while locked; out-of-range channels are consumed
  // without effect, so they do not count as a hit.
  assign wr_hit    = cfg_valid && locked_q && (32'(cfg_chan) < 32'(NUM_CLOCKS));
  assign cfg_ready = locked_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^{cfg_valid, cfg_chan, cfg_num, cfg_den};
  assign wr_hit     = 1'b0;
  assign cfg_ready  = 1'b0;
`endif

  // Per-channel accumulator step, ratio load and validity gating.
  always_comb begin
    num_d    = num_q;
    den_d    = den_q;
    acc_d    = acc_q;
    clken_d  = '0;
    outclk_d = outclk_q;
    sum      = '0;
    for (int unsigned c = 0; c < NUM_CLOCKS; c++) begin
      sum = {1'b0, acc_q[c]} + {1'b0, num_q[c]};
      if (wr_hit && (cfg_chan == CH_W'(c))) begin
        num_d[c]    = cfg_num;
        den_d[c]    = cfg_den;
        acc_d[c]    = '0;
        outclk_d[c] = 1'b0;
      end else if ((num_q[c] == '0) || (num_q[c] > den_q[c])) begin
        // Disabled channel (covers den=0): parked at zero.
        acc_d[c]    = '0;
        outclk_d[c] = 1'b0;
      end else if (sum >= {1'b0, den_q[c]}) begin
        acc_d[c]    = ACC_W'(sum - {1'b0, den_q[c]});
        clken_d[c]  = 1'b1;
        outclk_d[c] = ~outclk_q[c];
      end else begin
        acc_d[c]    = sum[ACC_W-1:0];
      end
    end
  end

  // Lock counter: saturates at LOCK_CYCLES, restarts on every accepted write.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q < LOCK_MAX) begin
      cnt_d = cnt_q + LCW'(1);
    end
    if (wr_hit) begin
      cnt_d = '0;
    end
    locked_d = (cnt_d == LOCK_MAX);
  end

  // State registers, all cleared asynchronously to the 1/1 defaults.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      num_q    <= {NUM_CLOCKS{ACC_W'(1)}};
      den_q    <= {NUM_CLOCKS{ACC_W'(1)}};
      acc_q    <= '0;
      clken_q  <= '0;
      outclk_q <= '0;
      cnt_q    <= '0;
      locked_q <= 1'b0;
    end else begin
      num_q    <= num_d;
      den_q    <= den_d;
      acc_q    <= acc_d;
      clken_q  <= clken_d;
      outclk_q <= outclk_d;
      cnt_q    <= cnt_d;
      locked_q <= locked_d;
    end
  end

  assign clken  = clken_q;
  assign outclk = outclk_q;
  assign locked = locked_q;

endmodule

// File: tb/tb_video_clken_gen.sv
// Directed testbench for video_clken_gen (NUM_CLOCKS=3, ACC_W=16, LOCK_CYCLES=8).
// Covers the configurable build when VIDEO_CLKGEN_CFG_EN is defined and the
// fixed 1/1 build otherwise.
`timescale 1ns/1ps
module tb_video_clken_gen;

  localparam int LC = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_valid = 1'b0;
  logic [1:0]  cfg_chan = '0;
  logic [15:0] cfg_num = '0;
  logic [15:0] cfg_den = '0;
  logic        cfg_ready;
  logic [2:0]  clken;
  logic [2:0]  outclk;
  logic        locked;

  int vectors     = 0;
  int miscompares = 0;
  int edge_cnt    = 0;  // edges since last reset release
  int e1          = 0;  // edge of the latest ratio load on channel 1
  int ch1_div     = 1;  // den/num of channel 1 (integer ratios only)

  video_clken_gen #(
    .NUM_CLOCKS (3),
    .ACC_W      (16),
    .LOCK_CYCLES(LC)
  ) dut (
    .refclk   (clk),
    .rst      (rst),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_chan (cfg_chan),
    .cfg_num  (cfg_num),
    .cfg_den  (cfg_den),
    .clken    (clken),
    .outclk   (outclk),
    .locked   (locked)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Advance one edge and settle 1ns past it.
  task automatic tick;
    @(posedge clk);
    #1;
    edge_cnt++;
  endtask

  // Expected {outclk[1], clken[1]} for an integer ratio 1/ch1_div loaded at e1.
  function automatic logic [1:0] ch1_exp();
    int k;
    k = edge_cnt - e1;
    ch1_exp[0] = (k > 0) && ((k % ch1_div) == 0);
    ch1_exp[1] = ((k / ch1_div) % 2) == 1;
  endfunction

  task automatic test_reset;
    logic [2:0] exp_o;
    logic       exp_l;
    logic       exp_r;
    rst       = 1'b1;
    cfg_valid = 1'b0;
    tick;
    tick;
    vectors++;
    if ({clken, outclk, locked, cfg_ready} !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_hold: clken=%b outclk=%b locked=%b cfg_ready=%b, expected all 0",
               clken, outclk, locked, cfg_ready);
    end
    rst      = 1'b0;
    edge_cnt = 0;
    e1       = 0;
    ch1_div  = 1;
    for (int n = 1; n <= 10; n++) begin
      tick;
      exp_o = (n % 2 == 1) ? 3'b111 : 3'b000;
      exp_l = (n >= LC);
`ifdef VIDEO_CLKGEN_CFG_EN
      exp_r = exp_l;
`else
      exp_r = 1'b0;
`endif
      vectors++;
      if (clken !== 3'b111) begin
        miscompares++;
        $display("FAIL reset_clken edge %0d: got %b, expected 111", n, clken);
      end
      vectors++;
      if (outclk !== exp_o) begin
        miscompares++;
        $display("FAIL reset_outclk edge %0d: got %b, expected %b", n, outclk, exp_o);
      end
      vectors++;
      if (locked !== exp_l || cfg_ready !== exp_r) begin
        miscompares++;
        $display("FAIL reset_lock edge %0d: locked=%b cfg_ready=%b, expected %b/%b",
                 n, locked, cfg_ready, exp_l, exp_r);
      end
    end
  endtask

  task automatic test_reset_mid;
`ifdef VIDEO_CLKGEN_CFG_EN
    wait_locked();
    cfg_write(2'd2, 16'd1, 16'd3);
`endif
    tick;
    tick;
    tick;
    #3;
    rst = 1'b1;
    #1;
    vectors++;
    if ({clken, outclk, locked, cfg_ready} !== 8'h00) begin
      miscompares++;
      $display("FAIL async_reset: clken=%b outclk=%b locked=%b cfg_ready=%b, expected all 0",
               clken, outclk, locked, cfg_ready);
    end
    test_reset();
  endtask

`ifdef VIDEO_CLKGEN_CFG_EN
  task automatic wait_locked;
    int n;
    n = 0;
    while (locked !== 1'b1 && n < 40) begin
      tick;
      n++;
    end
    vectors++;
    if (locked !== 1'b1) begin
      miscompares++;
      $display("FAIL lock_timeout: locked=%b after %0d edges, expected 1", locked, n);
    end
  endtask

  // Offer one write; returns just after the accepting edge.
  task automatic cfg_write(input logic [1:0] ch, input logic [15:0] n, input logic [15:0] d);
    cfg_chan  = ch;
    cfg_num   = n;
    cfg_den   = d;
    cfg_valid = 1'b1;
    tick;
    cfg_valid = 1'b0;
  endtask

  task automatic test_quarter;
    logic exp02;
    wait_locked();
    cfg_write(2'd1, 16'd1, 16'd4);
    e1      = edge_cnt;
    ch1_div = 4;
    vectors++;
    if (locked !== 1'b0 || cfg_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL quarter_lock_drop: locked=%b cfg_ready=%b, expected 0/0", locked, cfg_ready);
    end
    vectors++;
    if (clken[1] !== 1'b0 || outclk[1] !== 1'b0) begin
      miscompares++;
      $display("FAIL quarter_load: clken1=%b outclk1=%b, expected 0/0", clken[1], outclk[1]);
    end
    for (int i = 1; i <= 16; i++) begin
      tick;
      exp02 = (edge_cnt % 2) == 1;
      vectors++;
      if ({outclk[1], clken[1]} !== ch1_exp()) begin
        miscompares++;
        $display("FAIL quarter_ch1 E+%0d: outclk1/clken1=%b, expected %b", i,
                 {outclk[1], clken[1]}, ch1_exp());
      end
      vectors++;
      if ({clken[2], clken[0]} !== 2'b11 || {outclk[2], outclk[0]} !== {exp02, exp02}) begin
        miscompares++;
        $display("FAIL quarter_others E+%0d: clken=%b outclk=%b, expected ch0/ch2 clken 1 outclk %b",
                 i, clken, outclk, exp02);
      end
      vectors++;
      if (locked !== (i >= LC)) begin
        miscompares++;
        $display("FAIL quarter_relock E+%0d: locked=%b, expected %b", i, locked, (i >= LC));
      end
    end
  endtask

  task automatic test_invalid_ratio;
    wait_locked();
    cfg_write(2'd0, 16'd5, 16'd3);
    for (int i = 0; i <= 10; i++) begin
      if (i > 0) tick;
      vectors++;
      if (clken[0] !== 1'b0 || outclk[0] !== 1'b0) begin
        miscompares++;
        $display("FAIL invalid_ch0 E+%0d: clken0=%b outclk0=%b, expected 0/0", i, clken[0], outclk[0]);
      end
      vectors++;
      if (locked !== (i >= LC) || {outclk[1], clken[1]} !== ch1_exp()) begin
        miscompares++;
        $display("FAIL invalid_side E+%0d: locked=%b ch1=%b, expected %b/%b", i, locked,
                 {outclk[1], clken[1]}, (i >= LC), ch1_exp());
      end
    end
  endtask

  // Write num=0 to ch0, then hold a ch1 write pending through the unlocked window.
  task automatic test_hold_unlocked;
    wait_locked();
    cfg_write(2'd0, 16'd0, 16'd1);
    cfg_chan  = 2'd1;
    cfg_num   = 16'd1;
    cfg_den   = 16'd2;
    cfg_valid = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick;
      if (i == 9) begin
        cfg_valid = 1'b0;
        vectors++;
        if (locked !== 1'b0 || clken[1] !== 1'b0 || outclk[1] !== 1'b0) begin
          miscompares++;
          $display("FAIL hold_accept: locked=%b clken1=%b outclk1=%b, expected 0/0/0",
                   locked, clken[1], outclk[1]);
        end
        e1      = edge_cnt;
        ch1_div = 2;
      end else begin
        vectors++;
        if (locked !== (i == LC) || cfg_ready !== (i == LC)) begin
          miscompares++;
          $display("FAIL hold_lock E+%0d: locked=%b cfg_ready=%b, expected %b", i, locked,
                   cfg_ready, (i == LC));
        end
        vectors++;
        if ({outclk[1], clken[1]} !== ch1_exp()) begin
          miscompares++;
          $display("FAIL hold_early_accept E+%0d: ch1=%b, expected %b", i,
                   {outclk[1], clken[1]}, ch1_exp());
        end
      end
      vectors++;
      if (clken[0] !== 1'b0 || outclk[0] !== 1'b0) begin
        miscompares++;
        $display("FAIL num0_ch0 E+%0d: clken0=%b outclk0=%b, expected 0/0", i, clken[0], outclk[0]);
      end
    end
    for (int i = 1; i <= 10; i++) begin
      tick;
      vectors++;
      if ({outclk[1], clken[1]} !== ch1_exp()) begin
        miscompares++;
        $display("FAIL half_ch1 +%0d: ch1=%b, expected %b", i, {outclk[1], clken[1]}, ch1_exp());
      end
    end
  endtask

  task automatic test_fraction;
    int pulses;
    int last;
    int first;
    wait_locked();
    cfg_write(2'd2, 16'd33, 16'd50);
    pulses = 0;
    last   = 0;
    first  = 0;
    for (int i = 1; i <= 100; i++) begin
      tick;
      if (clken[2] === 1'b1) begin
        if (first == 0) begin
          first = i;
        end else begin
          vectors++;
          if ((i - last) < 1 || (i - last) > 2) begin
            miscompares++;
            $display("FAIL frac_gap E+%0d: spacing %0d, expected 1 or 2", i, i - last);
          end
        end
        last = i;
        pulses++;
      end
      if (i % 50 == 0) begin
        vectors++;
        if (pulses !== 33) begin
          miscompares++;
          $display("FAIL frac_window ending E+%0d: %0d pulses, expected 33", i, pulses);
        end
        pulses = 0;
      end
      vectors++;
      if ({outclk[1], clken[1]} !== ch1_exp() || clken[0] !== 1'b0) begin
        miscompares++;
        $display("FAIL frac_others E+%0d: ch1=%b clken0=%b, expected %b/0", i,
                 {outclk[1], clken[1]}, clken[0], ch1_exp());
      end
    end
    vectors++;
    if (first !== 2) begin
      miscompares++;
      $display("FAIL frac_first: first pulse at E+%0d, expected E+2", first);
    end
  endtask

  task automatic test_bad_chan;
    wait_locked();
    cfg_write(2'd3, 16'd1, 16'd1);
    for (int i = 0; i <= 10; i++) begin
      if (i > 0) tick;
      vectors++;
      if (locked !== 1'b1 || cfg_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL badchan_lock E+%0d: locked=%b cfg_ready=%b, expected 1/1", i, locked, cfg_ready);
      end
      vectors++;
      if ({outclk[1], clken[1]} !== ch1_exp() || clken[0] !== 1'b0) begin
        miscompares++;
        $display("FAIL badchan_side E+%0d: ch1=%b clken0=%b, expected %b/0", i,
                 {outclk[1], clken[1]}, clken[0], ch1_exp());
      end
    end
  endtask
`else
  task automatic test_fixed_mode;
    logic exp_o;
    cfg_chan  = 2'd1;
    cfg_num   = 16'd1;
    cfg_den   = 16'd4;
    cfg_valid = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick;
      exp_o = (edge_cnt % 2) == 1;
      vectors++;
      if (clken !== 3'b111 || outclk !== {3{exp_o}}) begin
        miscompares++;
        $display("FAIL fixed_ratio +%0d: clken=%b outclk=%b, expected 111/%b", i, clken, outclk,
                 {3{exp_o}});
      end
      vectors++;
      if (locked !== 1'b1 || cfg_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL fixed_lock +%0d: locked=%b cfg_ready=%b, expected 1/0", i, locked, cfg_ready);
      end
    end
    cfg_valid = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
`ifdef VIDEO_CLKGEN_CFG_EN
    test_quarter();
    test_invalid_ratio();
    test_hold_unlocked();
    test_fraction();
    test_bad_chan();
`else
    test_fixed_mode();
`endif
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
